// File: rtl/prio_q_sys.sv
// -----------------------------------------------------------------------------
// prio_q_sys
// Single-cycle min-priority queue built as a sorted register array. Slot 0
// always holds the smallest key, so the head is available straight from a
// flop. Equal keys leave in arrival order (strict compare on insert).
//
// Optional feature macro: PRIO_Q_DROP_MAX_EN
//   defined   : enq_ready tied high; a push into a full queue without a pop
//               keeps the CAPACITY smallest elements and pulses ovf_drop.
//   undefined : a push into a full queue needs a same-cycle pop; ovf_drop = 0.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enq_valid/ready/data  push handshake (enq_ready = !full | deq_ready)
//   deq_valid/ready/data  pop handshake, deq_data is the current minimum
//   elem_cnt              number of stored elements
//   full/empty/almost_full occupancy flags
//   ovf_drop              one-cycle pulse when an element was discarded
// -----------------------------------------------------------------------------
module prio_q_sys #(
    parameter int unsigned  WIDTH     = 32,
    parameter int unsigned  CMP_WID   = 32,
    parameter int unsigned  CAPACITY  = 32,
    parameter int unsigned  AFULL_LVL = 28,
    localparam int unsigned CNT_W     = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic [CNT_W-1:0] elem_cnt,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             ovf_drop
);

    logic [WIDTH-1:0]    slot_q [CAPACITY];
    logic [WIDTH-1:0]    slot_d [CAPACITY];
    logic [WIDTH-1:0]    base   [CAPACITY];
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    base_cnt;
    logic [CAPACITY-1:0] ge;
    logic                full_q;
    logic                empty_q;
    logic                afull_q;
    logic                ovf_q;
    logic                ovf_d;
    logic                push;
    logic                pop;

    // Handshakes: deq_ready -> enq_ready is a deliberate combinational path
`ifdef PRIO_Q_DROP_MAX_EN
    assign enq_ready = 1'b1;
`else
    assign enq_ready = !full_q | deq_ready;
`endif
    assign push = enq_valid & enq_ready;
    assign pop  = deq_ready & !empty_q;

    // Next state: first apply the pop (shift down), then insert into the result
    always_comb begin
        base     = slot_q;
        base_cnt = cnt_q;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        ovf_d    = 1'b0;
        ge       = '0;

        if (pop) begin
            for (int i = 0; i < int'(CAPACITY) - 1; i++) begin
                base[i] = slot_q[i+1];
            end
            base[CAPACITY-1] = '0;
            base_cnt         = cnt_q - CNT_W'(1);
        end

        // ge[i]: slot i is at or above the insertion point (monotonic in i)
        for (int i = 0; i < int'(CAPACITY); i++) begin
            if (CNT_W'(i) < base_cnt) begin
                ge[i] = enq_data[CMP_WID-1:0] < base[i][CMP_WID-1:0];
            end else begin
                ge[i] = CNT_W'(i) == base_cnt;
            end
        end

        slot_d = base;
        cnt_d  = base_cnt;
        if (push) begin
            if (ge[0]) begin
                slot_d[0] = enq_data;
            end
            for (int i = 1; i < int'(CAPACITY); i++) begin
                if (ge[i]) begin
                    slot_d[i] = ge[i-1] ? base[i-1] : enq_data;
                end
            end
            // Full base: the top element (old or new) falls off the end
            if (base_cnt != CNT_W'(CAPACITY)) begin
                cnt_d = base_cnt + CNT_W'(1);
            end
`ifdef PRIO_Q_DROP_MAX_EN
            else begin
                ovf_d = 1'b1;
            end
`endif
        end
    end

    // State and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CAPACITY); i++) begin
                slot_q[i] <= '0;
            end
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == CNT_W'(CAPACITY);
            empty_q <= cnt_d == '0;
            afull_q <= cnt_d >= CNT_W'(AFULL_LVL);
            ovf_q   <= ovf_d;
        end
    end

    assign deq_data    = slot_q[0];
    assign deq_valid   = !empty_q;
    assign elem_cnt    = cnt_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
`ifdef PRIO_Q_DROP_MAX_EN
    assign ovf_drop    = ovf_q;
`else
    assign ovf_drop    = 1'b0;
`endif

endmodule

// File: tb/tb_prio_q_sys.sv
// -----------------------------------------------------------------------------
// tb_prio_q_sys
// Directed tests on a 4-entry queue, then a random run on a 32-entry queue,
// both checked against a sorted-FIFO reference model with a scoreboard of
// expected pop data.
// -----------------------------------------------------------------------------
module tb_prio_q_sys;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 8;

`ifdef PRIO_Q_DROP_MAX_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Small instance for directed tests
    logic         a_ev, a_dr, a_er, a_dv, a_full, a_empty, a_af, a_ovf;
    logic [W-1:0] a_ed, a_dd;
    logic [2:0]   a_cnt;

    prio_q_sys #(.WIDTH(W), .CMP_WID(CW), .CAPACITY(4), .AFULL_LVL(3)) u_a (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(a_ev), .enq_ready(a_er), .enq_data(a_ed),
        .deq_valid(a_dv), .deq_ready(a_dr), .deq_data(a_dd),
        .elem_cnt(a_cnt), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .ovf_drop(a_ovf)
    );

    // Large instance for the random run
    logic         b_ev, b_dr, b_er, b_dv, b_full, b_empty, b_af, b_ovf;
    logic [W-1:0] b_ed, b_dd;
    logic [5:0]   b_cnt;

    prio_q_sys #(.WIDTH(W), .CMP_WID(CW), .CAPACITY(32), .AFULL_LVL(28)) u_b (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(b_ev), .enq_ready(b_er), .enq_data(b_ed),
        .deq_valid(b_dv), .deq_ready(b_dr), .deq_data(b_dd),
        .elem_cnt(b_cnt), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .ovf_drop(b_ovf)
    );

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] mq[$];      // reference model contents, sorted
    logic [W-1:0] exp_q[$];   // scoreboard of expected pop data
    int           cap = 4;
    int           afl = 3;
    bit           sel_b = 1'b0;
    bit           exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int tag, input int key);
        return (W'(tag) << 8) | W'(key & 255);
    endfunction

    // Sorted insert after existing equal keys; overflow drops the largest
    task automatic model_push(input logic [W-1:0] d);
        int pos;
        pos = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (d[CW-1:0] < mq[i][CW-1:0]) begin
                pos = i;
                break;
            end
        end
        mq.insert(pos, d);
        if (mq.size() > cap) void'(mq.pop_back());
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":cnt"},   sel_b ? W'(b_cnt) : W'(a_cnt), W'(mq.size()));
        chk({tag, ":full"},  W'(sel_b ? b_full : a_full), W'(mq.size() == cap));
        chk({tag, ":empty"}, W'(sel_b ? b_empty : a_empty), W'(mq.size() == 0));
        chk({tag, ":afull"}, W'(sel_b ? b_af : a_af), W'(mq.size() >= afl));
        chk({tag, ":ovf"},   W'(sel_b ? b_ovf : a_ovf), W'(exp_ovf));
        chk({tag, ":dvld"},  W'(sel_b ? b_dv : a_dv), W'(mq.size() != 0));
        chk({tag, ":data"},  sel_b ? b_dd : a_dd, (mq.size() != 0) ? mq[0] : '0);
    endtask

    // One cycle: drive just after a rising edge, sample mid-cycle, check after next edge
    task automatic step(input logic ev, input logic [W-1:0] ed, input logic dr);
        logic         er, dv;
        logic [W-1:0] dd;
        bit           exp_rdy, pu, po;
        a_ev = !sel_b & ev;  b_ev = sel_b & ev;
        a_dr = !sel_b & dr;  b_dr = sel_b & dr;
        a_ed = ed;           b_ed = ed;
        exp_rdy = DROP || (mq.size() != cap) || dr;
        pu = ev && exp_rdy;
        po = dr && (mq.size() != 0);
        if (po) exp_q.push_back(mq[0]);
        @(negedge clk);
        er = sel_b ? b_er : a_er;
        dv = sel_b ? b_dv : a_dv;
        dd = sel_b ? b_dd : a_dd;
        chk("enq_ready", W'(er), W'(exp_rdy));
        if (po && dv && exp_q.size() != 0) chk("pop_data", dd, exp_q.pop_front());
        exp_q.delete();
        exp_ovf = 1'b0;
        if (po) void'(mq.pop_front());
        if (pu) begin
            if (mq.size() == cap) exp_ovf = DROP;
            model_push(ed);
        end
        @(posedge clk);
        #1;
        check_state("step");
    endtask

    initial begin
        a_ev = 0; a_dr = 0; a_ed = '0;
        b_ev = 0; b_dr = 0; b_ed = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst_n = 1'b1;

        // Equal keys leave in arrival order
        step(1, mk(0, 7), 0);
        step(1, mk(0, 3), 0);
        step(1, mk(0, 9), 0);
        step(1, mk(1, 3), 0);
        repeat (4) step(0, '0, 1);

        // Push+pop on a full queue replaces the head
        step(1, mk(0, 10), 0);
        step(1, mk(0, 20), 0);
        step(1, mk(0, 30), 0);
        step(1, mk(0, 40), 0);
        step(1, mk(0, 5), 1);
        // Push into full without pop (rejected, or dropped in drop mode)
        step(1, mk(2, 99), 0);
        repeat (4) step(0, '0, 1);
        step(0, '0, 1);   // pop on empty is ignored

        // Overflow: smaller key displaces the largest, larger key is discarded
        step(1, mk(0, 10), 0);
        step(1, mk(0, 20), 0);
        step(1, mk(0, 30), 0);
        step(1, mk(0, 40), 0);
        step(1, mk(3, 25), 0);
        step(1, mk(3, 50), 0);
        step(0, '0, 0);   // ovf_drop must fall again
        repeat (4) step(0, '0, 1);

        // Asynchronous reset in the middle of a cycle
        step(1, mk(0, 4), 0);
        step(1, mk(0, 2), 0);
        step(1, mk(0, 6), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        exp_ovf = 1'b0;
        check_state("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, mk(0, 42), 0);
        step(0, '0, 1);

        // Random traffic on the 32-entry instance
        a_ev = 0; a_dr = 0;
        sel_b = 1'b1;
        cap = 32;
        afl = 28;
        mq.delete();
        for (int i = 0; i < 10000; i++) begin
            int pe, pd;
            case ((i / 1000) % 4)
                0:       begin pe = 80; pd = 30; end
                1:       begin pe = 50; pd = 50; end
                2:       begin pe = 20; pd = 75; end
                default: begin pe = 95; pd = 60; end
            endcase
            step($urandom_range(0, 99) < pe, mk(i & 16'hffff, $urandom_range(0, 31)),
                 $urandom_range(0, 99) < pd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
